uart_tx_drain: RTL

UART transmitter that sits directly downstream of the team's synchronous FIFO and drains it. Whenever the FIFO reports non-empty and the transmitter is idle, it captures the FIFO head word, pops it with a one-cycle read pulse, and serializes it as 8N1-style asynchronous serial: start bit, DBIT data bits LSB first, then stop time. It contains its own oversample baud divider, so no external tick source is needed.

---
 rtl/uart_tx_drain.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains a FIFO and sends each word as start, DBIT data bits (LSB first), stop; has its own baud divider
// Ports: clk; reset (async, active-high); fifo_empty/fifo_data = FIFO head; rd = one-cycle pop strobe;
//        tx = serial line (idles high); tx_busy = frame in progress; tx_done_tick = pulse after each frame.
module uart_tx_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int SMAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q, state_d;
  logic [DVSR_W-1:0] d_q, d_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              tx_q, tx_d, rd_q, rd_d, done_q, done_d, s_tick;
  // divider is held in IDLE so each frame starts on a fresh tick phase
  assign s_tick = (state_q != IDLE) && (d_q == DVSR_W'(DVSR - 1));
  always_comb d_d = (state_q == IDLE || s_tick) ? '0 : d_q + DVSR_W'(1);
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        state_d = START;
        b_d     = fifo_data;
        s_d     = '0;
        n_d     = '0;
        rd_d    = 1'b1;
      end
      START: if (s_tick) begin
        if (s_q == SW'(15)) begin
          state_d = DATA;
          s_d     = '0;
        end else s_d = s_q + SW'(1);
      end
      DATA: if (s_tick) begin
        if (s_q == SW'(15)) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NW'(DBIT - 1)) state_d = STOP;
          else n_d = n_q + NW'(1);
        end else s_d = s_q + SW'(1);
      end
      default: if (s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else s_d = s_q + SW'(1);
      end
    endcase
    // tx is registered, so derive it from the state and shift register being entered
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? b_d[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end
  assign rd           = rd_q;
  assign tx           = tx_q;
  assign tx_busy      = state_q != IDLE;
  assign tx_done_tick = done_q;
endmodule
